im_fb_arbiter: RTL

//  Arbiter for the single-port image-memory framebuffer BRAM shared by the VGA scan-out and the CPU.

---
 rtl/im_fb_arbiter_if.sv | 23 ++
 rtl/im_fb_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/im_fb_arbiter_if.sv
// CPU peripheral-bus port of the framebuffer arbiter: request held until a one-cycle ready pulse.
interface im_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_err
  );
endinterface

// File: rtl/im_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA fetch wins, CPU uses free cycles, starving CPU overrides.
// Grant drives the BRAM in the same cycle; cpu_ready follows one cycle later, rgb two cycles later.
module im_fb_arbiter #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 15,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int SCALE_SH   = 2,
  parameter int FB_DEPTH   = 19200,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  output logic [DATA_W-1:0] rgb,
  im_fb_arbiter_if.slave    cpu,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       underrun_cnt
);
  localparam int                FB_W      = H_RES >> SCALE_SH;
  localparam int                WC_W      = $clog2(STARVE_LIM + 1);
  localparam logic [9:0]        H_LIM     = 10'(H_RES);
  localparam logic [9:0]        V_LIM     = 10'(V_RES);
  localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(FB_W);
  localparam logic [WC_W-1:0]   LIM       = WC_W'(STARVE_LIM);

  typedef enum logic [2:0] {IDLE, VGA_RD, CPU_RD, CPU_WR, CPU_ERR} state_t;

  state_t            state;
  logic [WC_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0] last_vaddr;
  logic              lv_valid;
  logic              vis_d1;
  logic              ready_q;
  logic              err_q;

  logic              vis;
  logic              vga_need;
  logic              cpu_prev;
  logic              starve;
  logic              oob;
  logic              grant_cpu;
  logic              grant_vga;
  logic              cpu_acc;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] vaddr;

  always_comb begin
    row       = ADDR_W'(pixel_y >> SCALE_SH);
    col       = ADDR_W'(pixel_x >> SCALE_SH);
    vaddr     = row * ROW_WORDS + col;
    vis       = video_on && (pixel_x < H_LIM) && (pixel_y < V_LIM);
    vga_need  = vis && (!lv_valid || (vaddr != last_vaddr));
    // The state remembers last cycle's grant; a CPU grant then means ready is on the bus now.
    cpu_prev  = (state == CPU_RD) || (state == CPU_WR) || (state == CPU_ERR);
    starve    = !reset && cpu.cpu_req && (wait_cnt >= LIM);
    oob       = cpu.cpu_addr >= DEPTH;
    grant_cpu = starve || (!reset && cpu.cpu_req && !vga_need && !cpu_prev);
    grant_vga = !reset && vga_need && !starve;
    cpu_acc   = grant_cpu && !oob;
    mem_en    = grant_vga || cpu_acc;
    mem_we    = cpu_acc && cpu.cpu_we;
    mem_addr  = cpu_acc ? cpu.cpu_addr : (grant_vga ? vaddr : '0);
    mem_wdata = mem_we ? cpu.cpu_wdata : '0;
  end

  assign cpu.cpu_ready = ready_q;
  assign cpu.cpu_err   = err_q;
  assign cpu.cpu_rdata = (state == CPU_RD) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      last_vaddr   <= '0;
      lv_valid     <= 1'b0;
      vis_d1       <= 1'b0;
      rgb          <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (grant_vga)      state <= VGA_RD;
      else if (grant_cpu) state <= oob ? CPU_ERR : (cpu.cpu_we ? CPU_WR : CPU_RD);
      else                state <= IDLE;

      ready_q <= grant_cpu;
      err_q   <= grant_cpu && oob;

      if (grant_cpu || !cpu.cpu_req) wait_cnt <= '0;
      else if (wait_cnt != LIM)      wait_cnt <= wait_cnt + 1'b1;

      // Forgetting the last address during blanking forces a fetch at the start of each line.
      if (!vis) begin
        lv_valid <= 1'b0;
      end else if (grant_vga) begin
        last_vaddr <= vaddr;
        lv_valid   <= 1'b1;
      end

      vis_d1 <= vis;
      if (state == VGA_RD) rgb <= mem_rdata;
      else if (!vis_d1)    rgb <= '0;

      if (starve && vga_need && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
endmodule
